// File: rtl/gray_ptr_sync_if.sv
// Gray pointer CDC bundle: foreign-domain pointer in, synchronized views out.
interface gray_ptr_sync_if #(
  parameter int unsigned DATA_WIDTH = 2
);
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_sync_o;
  logic [DATA_WIDTH-1:0] bin_o;
  logic                  change_o;

  modport master (
    output data_i,
    input  data_sync_o,
    input  bin_o,
    input  change_o
  );

  modport slave (
    input  data_i,
    output data_sync_o,
    output bin_o,
    output change_o
  );
endinterface

// File: rtl/gray_ptr_sync.sv
// Gray-coded pointer synchronizer: a flop chain in the destination clock
// domain, a combinational Gray-to-binary decode of the last stage, and a
// registered one-cycle pulse whenever the synchronized value changes.
module gray_ptr_sync #(
  parameter int unsigned DATA_WIDTH  = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  gray_ptr_sync_if.slave  bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("gray_ptr_sync: SYNC_STAGES must be in 2..4");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_width
    $error("gray_ptr_sync: DATA_WIDTH must be in 1..32");
  end

  (* ASYNC_REG = "TRUE" *) logic [DATA_WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] stage_d [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] prev_d;
  logic                  change_q;
  logic                  change_d;
  logic [DATA_WIDTH-1:0] sync_w;
  logic [DATA_WIDTH-1:0] bin_w;

  assign sync_w = stage_q[SYNC_STAGES-1];

  // Pure wiring between stages: nothing may sit in front of a synchronizer flop.
  always_comb begin
    stage_d[0] = bus.data_i;
    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Change detect: compare the synchronized value against its one-cycle delay.
  always_comb begin
    prev_d   = sync_w;
    change_d = (sync_w != prev_q);
  end

  // Synchronizer chain, delay register and change flag; async clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        stage_q[k] <= '0;
      end
      prev_q   <= '0;
      change_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
      prev_q   <= prev_d;
      change_q <= change_d;
    end
  end

  // Gray-to-binary: bin[i] is the XOR of all synchronized bits from i upward.
  always_comb begin
    bin_w = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      bin_w[i] = ^(sync_w >> i);
    end
  end

  assign bus.data_sync_o = sync_w;
  assign bus.bin_o       = bin_w;
  assign bus.change_o    = change_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Scoreboard bench for gray_ptr_sync: three configurations (W2/S2, W4/S2,
// W2/S3) share clock and reset; a driver queues expected updates and a
// negedge monitor retires them as the synchronized outputs move.
module tb_gray_ptr_sync;

  localparam int unsigned NI = 3;
  localparam int unsigned W_TAB [NI] = '{2, 4, 2};
  localparam int unsigned S_TAB [NI] = '{2, 2, 3};

  typedef struct {
    logic [3:0]  gray;
    logic [3:0]  bin;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [3:0] din    [NI];
  logic [3:0] sync_w [NI];
  logic [3:0] bin_w  [NI];
  logic       chg_w  [NI];
  logic [3:0] last   [NI];
  logic       chg_exp[NI];
  exp_t       sb_q   [NI][$];

  gray_ptr_sync_if #(.DATA_WIDTH(2)) if0 ();
  gray_ptr_sync_if #(.DATA_WIDTH(4)) if1 ();
  gray_ptr_sync_if #(.DATA_WIDTH(2)) if2 ();

  gray_ptr_sync #(.DATA_WIDTH(2), .SYNC_STAGES(2)) u0 (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
  gray_ptr_sync #(.DATA_WIDTH(4), .SYNC_STAGES(2)) u1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));
  gray_ptr_sync #(.DATA_WIDTH(2), .SYNC_STAGES(3)) u2 (.clk_i(clk), .rst_i(rst), .bus(if2.slave));

  assign if0.data_i = din[0][1:0];
  assign if1.data_i = din[1];
  assign if2.data_i = din[2][1:0];
  assign sync_w[0] = {2'b00, if0.data_sync_o};
  assign sync_w[1] = if1.data_sync_o;
  assign sync_w[2] = {2'b00, if2.data_sync_o};
  assign bin_w[0]  = {2'b00, if0.bin_o};
  assign bin_w[1]  = if1.bin_o;
  assign bin_w[2]  = {2'b00, if2.bin_o};
  assign chg_w[0]  = if0.change_o;
  assign chg_w[1]  = if1.change_o;
  assign chg_w[2]  = if2.change_o;

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Rank of a Gray code: the binary count whose reflected code equals it.
  function automatic logic [3:0] gray_rank(logic [3:0] g);
    for (int b = 0; b < 16; b++) begin
      if (4'(b ^ (b >> 1)) == g) return 4'(b);
    end
    return '0;
  endfunction

  function automatic logic [3:0] to_gray(int unsigned b);
    return 4'(b ^ (b >> 1));
  endfunction

  function automatic logic [3:0] wmask(int i, logic [3:0] v);
    return v & 4'((1 << W_TAB[i]) - 1);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Changes data_i; a value present before edge cyc+1 shows up at cyc+S.
  task automatic drive(int i, logic [3:0] v);
    logic [3:0] m;
    exp_t e;
    m = wmask(i, v);
    if (m != din[i]) begin
      din[i] = m;
      if (!rst) begin
        e.gray = m;
        e.bin  = gray_rank(m);
        e.cyc  = cyc + S_TAB[i];
        sb_q[i].push_back(e);
      end
    end
  endtask

  task automatic check_all_zero(string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s u%0d sync", tag, i), 32'(sync_w[i]), 0);
      chk($sformatf("%s u%0d bin", tag, i), 32'(bin_w[i]), 0);
      chk($sformatf("%s u%0d change", tag, i), 32'(chg_w[i]), 0);
    end
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) sb_q[i].delete();
    #1;
    check_all_zero("reset_async");
  endtask

  // After release the model state is 0, so a nonzero input is a pending update.
  task automatic release_reset();
    exp_t e;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      if (din[i] != 4'd0) begin
        e.gray = din[i];
        e.bin  = gray_rank(din[i]);
        e.cyc  = cyc + S_TAB[i];
        sb_q[i].push_back(e);
      end
    end
  endtask

  // Monitor: retire one expected update per observed output change.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        last[i]    = '0;
        chg_exp[i] = 1'b0;
      end else begin
        chk($sformatf("u%0d change", i), 32'(chg_w[i]), 32'(chg_exp[i]));
        chg_exp[i] = 1'b0;
        if (sync_w[i] !== last[i]) begin
          if (sb_q[i].size() == 0) begin
            chk($sformatf("u%0d unexpected update", i), 32'(sync_w[i]), 32'(last[i]));
          end else begin
            e = sb_q[i].pop_front();
            chk($sformatf("u%0d sync", i), 32'(sync_w[i]), 32'(e.gray));
            chk($sformatf("u%0d bin", i), 32'(bin_w[i]), 32'(e.bin));
            chk($sformatf("u%0d latency", i), cyc, e.cyc);
          end
          last[i]    = sync_w[i];
          chg_exp[i] = 1'b1;
        end else if (sb_q[i].size() != 0 && sb_q[i][0].cyc < cyc) begin
          e = sb_q[i].pop_front();
          chk($sformatf("u%0d missed update", i), 32'(sync_w[i]), 32'(e.gray));
        end
      end
    end
  end

  initial begin
    bit pending;
    din[0] = 4'b0011;
    din[1] = 4'b1000;
    din[2] = 4'b0011;

    // Reset with the clock stopped: outputs must clear with no edge.
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("reset_noclk");
    clk_en = 1'b1;

    // Reset held while the clock runs and the inputs wander.
    for (int n = 0; n < 3; n++) begin
      step();
      for (int i = 0; i < NI; i++) din[i] = wmask(i, 4'($urandom));
      check_all_zero("reset_held");
    end
    din[0] = 4'b0011;
    din[1] = 4'b1000;
    din[2] = 4'b0011;
    step();
    release_reset();
    repeat (5) step();

    // W=2 Gray count, one value per 4 cycles.
    begin
      logic [3:0] seq [5];
      seq = '{4'b00, 4'b01, 4'b11, 4'b10, 4'b00};
      for (int k = 0; k < 5; k++) begin
        drive(0, seq[k]);
        drive(2, seq[k]);
        repeat (4) step();
      end
    end

    // W=4 wrap and an intermediate code (1000 is already in place -> 15).
    drive(1, 4'b0000);
    repeat (4) step();
    drive(1, 4'b0110);
    repeat (4) step();
    drive(1, 4'b1000);
    repeat (4) step();
    drive(1, 4'b0000);
    repeat (4) step();

    // W=4 back-to-back: a new Gray code on every edge.
    for (int unsigned b = 1; b < 16; b++) begin
      drive(1, to_gray(b));
      step();
    end
    repeat (5) step();

    // Randomized single-bit Gray steps on all instances.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NI; i++) begin
        if ($urandom_range(2) == 0) begin
          drive(i, din[i] ^ 4'(1 << $urandom_range(W_TAB[i] - 1)));
        end
      end
      step();
    end
    repeat (5) step();

    // Reset mid-stream while 0111 sits in the first stage of the W=4 path.
    drive(1, 4'b0111);
    step();
    assert_reset();
    step();
    step();
    release_reset();
    repeat (6) step();

    // Drain any outstanding expectations.
    for (int n = 0; n < 12; n++) begin
      pending = 1'b0;
      for (int i = 0; i < NI; i++) if (sb_q[i].size() != 0) pending = 1'b1;
      if (!pending) break;
      step();
    end
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d drained", i), 32'(sb_q[i].size()), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
